ddr3_arbiter: RTL

DDR3_ARBITER -- requirements
Module: ddr3_arbiter

---
 rtl/ddr3_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ddr3_arbiter.sv
// ddr3_arbiter: two-requester arbiter in front of a DDR3 controller (m0 = dcache, m1 = icache).
// Define DDR3_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority over m1.
module ddr3_arbiter #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_we_i,
    input  logic              m0_rd_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_we_i,
    input  logic              m1_rd_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic [ADDR_W-1:0] ddr_addr_o,
    output logic [DATA_W-1:0] ddr_data_o,
    output logic              ddr_we_o,
    output logic              ddr_rd_o,
    input  logic [DATA_W-1:0] ddr_data_i,
    input  logic              ddr_ack_i,
    output logic              ready_o
);
    typedef enum logic [1:0] {INIT, IDLE, BUSY, GAP} state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              gnt_q, gnt_d;
    logic              ddr_we_q, ddr_we_d;
    logic              ddr_rd_q, ddr_rd_d;
    logic [ADDR_W-1:0] ddr_addr_q, ddr_addr_d;
    logic [DATA_W-1:0] ddr_data_q, ddr_data_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_data_q, m0_data_d;
    logic [DATA_W-1:0] m1_data_q, m1_data_d;
    logic              req0, req1, pick, sel_rd;

    assign req0 = m0_rd_i | m0_we_i;
    assign req1 = m1_rd_i | m1_we_i;

`ifdef DDR3_ARB_RR_EN
    logic rr_q, rr_d;
    assign pick = (req0 & req1) ? rr_q : ~req0;
`else
    assign pick = ~req0;
`endif

    // a requester asserting both rd and we gets the read first
    assign sel_rd = pick ? m1_rd_i : m0_rd_i;

    // next-state and next-output computation for the grant/ack sequence
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        gnt_d      = gnt_q;
        ddr_we_d   = ddr_we_q;
        ddr_rd_d   = ddr_rd_q;
        ddr_addr_d = ddr_addr_q;
        ddr_data_d = ddr_data_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_data_d  = m0_data_q;
        m1_data_d  = m1_data_q;
`ifdef DDR3_ARB_RR_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            INIT: begin
                if (ddr_ack_i) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (req0 | req1) begin
                    state_d    = BUSY;
                    gnt_d      = pick;
                    ddr_rd_d   = sel_rd;
                    ddr_we_d   = ~sel_rd;
                    ddr_addr_d = pick ? m1_addr_i : m0_addr_i;
                    ddr_data_d = pick ? m1_data_i : m0_data_i;
`ifdef DDR3_ARB_RR_EN
                    rr_d       = ~pick;
`endif
                end
            end
            BUSY: begin
                if (ddr_ack_i) begin
                    state_d  = GAP;
                    ddr_we_d = 1'b0;
                    ddr_rd_d = 1'b0;
                    m0_ack_d = ~gnt_q;
                    m1_ack_d = gnt_q;
                    m0_data_d = (ddr_rd_q && !gnt_q) ? ddr_data_i : m0_data_q;
                    m1_data_d = (ddr_rd_q && gnt_q) ? ddr_data_i : m1_data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset drops any in-flight ddr request at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            ready_q    <= 1'b0;
            gnt_q      <= 1'b0;
            ddr_we_q   <= 1'b0;
            ddr_rd_q   <= 1'b0;
            ddr_addr_q <= '0;
            ddr_data_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_data_q  <= '0;
            m1_data_q  <= '0;
`ifdef DDR3_ARB_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            gnt_q      <= gnt_d;
            ddr_we_q   <= ddr_we_d;
            ddr_rd_q   <= ddr_rd_d;
            ddr_addr_q <= ddr_addr_d;
            ddr_data_q <= ddr_data_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_data_q  <= m0_data_d;
            m1_data_q  <= m1_data_d;
`ifdef DDR3_ARB_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign ready_o    = ready_q;
    assign ddr_we_o   = ddr_we_q;
    assign ddr_rd_o   = ddr_rd_q;
    assign ddr_addr_o = ddr_addr_q;
    assign ddr_data_o = ddr_data_q;
    assign m0_ack_o   = m0_ack_q;
    assign m1_ack_o   = m1_ack_q;
    assign m0_data_o  = m0_data_q;
    assign m1_data_o  = m1_data_q;
endmodule
